// File: rtl/dice_race_pkg.sv
// Board geometry shared by the tile locator and the tile-index-to-coordinate mapper.
package dice_race_pkg;

  localparam int NUM_TILES  = 11;
  localparam int TILE_PITCH = 60;
  localparam int TILE_W     = 40;
  localparam int TILE_H     = 40;
  localparam int ROW_Y_TOP  = 100;

  typedef logic [3:0] tile_idx_t;

  localparam tile_idx_t TILE_NONE = 4'hF;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } locator_state_e;

endpackage

// File: rtl/tile_x_tracker.sv
// Divider-free horizontal tile tracker: follows the scan x position with
// segment/tile counters locked at x==0 and flags out-of-order pixels.
module tile_x_tracker
  import dice_race_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_pix_valid,
  input  logic [9:0] i_pix_x,
  output logic       o_track,
  output logic [5:0] o_seg_cur,
  output tile_idx_t  o_tile_cur,
  output logic       o_sync_err
);

  localparam logic [5:0] SEG_LAST = 6'(TILE_PITCH - 1);
  localparam tile_idx_t  TILE_SAT = 4'(NUM_TILES);

  locator_state_e r_state;
  locator_state_e w_state_next;
  logic [5:0]     r_seg_cnt;
  tile_idx_t      r_tile_cnt;
  logic [9:0]     r_exp_x;

  // Counters only move on tracked pixels; the next expected x is always pix_x+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= UNLOCKED;
      r_seg_cnt  <= '0;
      r_tile_cnt <= '0;
      r_exp_x    <= '0;
    end else begin
      r_state <= w_state_next;
      if (o_track) begin
        r_seg_cnt  <= o_seg_cur;
        r_tile_cnt <= o_tile_cur;
        r_exp_x    <= i_pix_x + 10'd1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_track      = 1'b0;
    o_seg_cur    = '0;
    o_tile_cur   = '0;
    o_sync_err   = 1'b0;
    if (i_pix_valid) begin
      if (i_pix_x == 10'd0) begin
        o_track      = 1'b1;
        w_state_next = LOCKED;
      end else if (r_state == LOCKED) begin
        if (i_pix_x == r_exp_x) begin
          o_track = 1'b1;
          if (r_seg_cnt == SEG_LAST) begin
            o_seg_cur  = '0;
            o_tile_cur = (r_tile_cnt == TILE_SAT) ? r_tile_cnt : r_tile_cnt + 4'd1;
          end else begin
            o_seg_cur  = r_seg_cnt + 6'd1;
            o_tile_cur = r_tile_cnt;
          end
        end else begin
          o_sync_err   = 1'b1;
          w_state_next = UNLOCKED;
        end
      end
    end
  end

endmodule

// File: rtl/tile_pixel_locator.sv
// Maps the display scan (x, y) to board tile index and in-tile offset, 1-cycle latency.
// Optional border flag enabled by defining TILE_PIXEL_BORDER_EN.
module tile_pixel_locator
  import dice_race_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_valid,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic       out_valid,
  output logic [3:0] tile_idx,
  output logic [5:0] local_x,
  output logic [5:0] local_y,
  output logic       in_tile,
  output logic       on_border,
  output logic       sync_err
);

  localparam logic [9:0] Y_TOP    = 10'(ROW_Y_TOP);
  localparam logic [9:0] Y_END    = 10'(ROW_Y_TOP + TILE_H);
  localparam logic [5:0] SEG_W    = 6'(TILE_W);
  localparam tile_idx_t  TILE_SAT = 4'(NUM_TILES);

  logic       w_track;
  logic [5:0] w_seg_cur;
  tile_idx_t  w_tile_cur;
  logic       w_sync_err;
  logic       w_y_in;
  logic       w_hit;
  logic [5:0] w_local_y;

  logic       r_out_valid;
  tile_idx_t  r_tile_idx;
  logic [5:0] r_local_x;
  logic [5:0] r_local_y;
  logic       r_in_tile;
  logic       r_sync_err;

  tile_x_tracker u_x_tracker (
    .clk         (clk),
    .reset       (reset),
    .i_pix_valid (pix_valid),
    .i_pix_x     (pix_x),
    .o_track     (w_track),
    .o_seg_cur   (w_seg_cur),
    .o_tile_cur  (w_tile_cur),
    .o_sync_err  (w_sync_err)
  );

  // Both bounds tested at full width so rows above the board cannot wrap into a hit.
  assign w_y_in    = (pix_y >= Y_TOP) && (pix_y < Y_END);
  assign w_hit     = w_track && (w_tile_cur < TILE_SAT) && (w_seg_cur < SEG_W) && w_y_in;
  assign w_local_y = 6'(pix_y - Y_TOP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_tile_idx  <= TILE_NONE;
      r_local_x   <= '0;
      r_local_y   <= '0;
      r_in_tile   <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_out_valid <= pix_valid;
      r_sync_err  <= w_sync_err;
      if (pix_valid) begin
        r_in_tile  <= w_hit;
        r_tile_idx <= w_hit ? w_tile_cur : TILE_NONE;
        r_local_x  <= w_hit ? w_seg_cur : 6'd0;
        r_local_y  <= w_hit ? w_local_y : 6'd0;
      end
    end
  end

`ifdef TILE_PIXEL_BORDER_EN
  logic w_border;
  logic r_on_border;

  assign w_border = w_hit && ((w_seg_cur == 6'd0) || (w_seg_cur == 6'(TILE_W - 1)) ||
                              (w_local_y == 6'd0) || (w_local_y == 6'(TILE_H - 1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_on_border <= 1'b0;
    end else if (pix_valid) begin
      r_on_border <= w_border;
    end
  end

  assign on_border = r_on_border;
`else
  assign on_border = 1'b0;
`endif

  assign out_valid = r_out_valid;
  assign tile_idx  = r_tile_idx;
  assign local_x   = r_local_x;
  assign local_y   = r_local_y;
  assign in_tile   = r_in_tile;
  assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_tile_pixel_locator.sv
// Bench for tile_pixel_locator: directed scan lines with literal pins plus random
// scans, all outputs checked every cycle against an arithmetic (x/60, x%60) model.
module tb_tile_pixel_locator;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_valid;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       out_valid;
  logic [3:0] tile_idx;
  logic [5:0] local_x;
  logic [5:0] local_y;
  logic       in_tile;
  logic       on_border;
  logic       sync_err;

`ifdef TILE_PIXEL_BORDER_EN
  localparam int BEXP = 1;
`else
  localparam int BEXP = 0;
`endif

  always #5 clk = ~clk;

  tile_pixel_locator dut (
    .clk       (clk),
    .reset     (reset),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .out_valid (out_valid),
    .tile_idx  (tile_idx),
    .local_x   (local_x),
    .local_y   (local_y),
    .in_tile   (in_tile),
    .on_border (on_border),
    .sync_err  (sync_err)
  );

  // Pin modes: 1 = out_valid/sync_err only, 2 = all tile fields, 3 = border only.
  typedef struct {
    int x; int mode; int ov; int it; int tl; int lx; int ly; int sy; int b;
  } pin_t;

  pin_t  pq[$];
  string pq_name[$];
  pin_t  cur_pin;
  string cur_name;
  bit    done = 1'b0;
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic drive(input logic r, input logic v, input int x, input int y);
    @(negedge clk);
    reset     = r;
    pix_valid = v;
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    cur_pin.mode = 0;
  endtask

  task automatic add(input string n, input int x, input int it, input int tl,
                     input int lx, input int ly, input int sy);
    pq.push_back('{x, 2, 1, it, tl, lx, ly, sy, 0});
    pq_name.push_back(n);
  endtask

  task automatic addb(input string n, input int x, input int b);
    pq.push_back('{x, 3, 1, 0, 0, 0, 0, 0, b});
    pq_name.push_back(n);
  endtask

  task automatic line(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) begin
      drive(1'b0, 1'b1, x, y);
      foreach (pq[i]) begin
        if (pq[i].x == x) begin
          cur_pin  = pq[i];
          cur_name = pq_name[i];
        end
      end
    end
    pq.delete();
    pq_name.delete();
  endtask

  task automatic chk(input string n, input int got, input int expv);
    n_checks++;
    if (got != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (x=%0d y=%0d t=%0t)", n, got, expv, pix_x, pix_y, $time);
    end
  endtask

  // Reference model: a locked pixel's true column is pix_x, so tile/offset are plain div/mod.
  task automatic compare_loop();
    int m_locked = 0;
    int m_exp = 0;
    int e_ov = 0, e_in = 0, e_tile = 15, e_lx = 0, e_ly = 0, e_b = 0, e_sy = 0;
    int x, y;
    bit track, hit;
    while (!done) begin
      @(posedge clk);
      #1;
      if (reset) begin
        e_ov = 0; e_in = 0; e_tile = 15; e_lx = 0; e_ly = 0; e_b = 0; e_sy = 0;
        m_locked = 0; m_exp = 0;
      end else if (!pix_valid) begin
        e_ov = 0; e_sy = 0;
      end else begin
        x = int'(pix_x);
        y = int'(pix_y);
        track = (x == 0) || (m_locked != 0 && x == m_exp);
        e_sy = (m_locked != 0 && x != 0 && x != m_exp) ? 1 : 0;
        if (track) begin
          m_locked = 1;
          m_exp = (x + 1) % 1024;
        end else begin
          m_locked = 0;
        end
        hit = track && (x / 60) < 11 && (x % 60) < 40 && y >= 100 && y < 140;
        e_ov = 1;
        e_in = hit ? 1 : 0;
        e_tile = hit ? x / 60 : 15;
        e_lx = hit ? x % 60 : 0;
        e_ly = hit ? y - 100 : 0;
        e_b = (BEXP != 0 && hit && (e_lx == 0 || e_lx == 39 || e_ly == 0 || e_ly == 39)) ? 1 : 0;
      end
      chk("out_valid", int'(out_valid), e_ov);
      chk("sync_err",  int'(sync_err),  e_sy);
      chk("in_tile",   int'(in_tile),   e_in);
      chk("tile_idx",  int'(tile_idx),  e_tile);
      chk("local_x",   int'(local_x),   e_lx);
      chk("local_y",   int'(local_y),   e_ly);
      chk("on_border", int'(on_border), e_b);
      if (cur_pin.mode == 1 || cur_pin.mode == 2) begin
        chk({cur_name, "/out_valid"}, int'(out_valid), cur_pin.ov);
        chk({cur_name, "/sync_err"},  int'(sync_err),  cur_pin.sy);
      end
      if (cur_pin.mode == 2) begin
        chk({cur_name, "/in_tile"},  int'(in_tile),  cur_pin.it);
        chk({cur_name, "/tile_idx"}, int'(tile_idx), cur_pin.tl);
        chk({cur_name, "/local_x"},  int'(local_x),  cur_pin.lx);
        chk({cur_name, "/local_y"},  int'(local_y),  cur_pin.ly);
      end
      if (cur_pin.mode == 3) begin
        chk({cur_name, "/on_border"}, int'(on_border), cur_pin.b);
      end
      if (cur_pin.mode != 0) begin
        $display("pin %s: x=%0d y=%0d valid=%0d in_tile=%0d tile=%0d lx=%0d ly=%0d border=%0d sync=%0d",
                 cur_name, pix_x, pix_y, out_valid, in_tile, tile_idx, local_x, local_y, on_border, sync_err);
      end
    end
  endtask

  task automatic stimulus();
    int ys[8];
    int y, x, xend, r;
    ys = '{99, 100, 101, 120, 138, 139, 140, 0};

    drive(1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 0, 0);
    cur_pin = '{0, 2, 0, 0, 15, 0, 0, 0, 0};
    cur_name = "reset_state";

    // Full line through the middle of the row, past the last tile.
    add("x0", 0, 1, 0, 0, 20, 0);
    add("x5", 5, 1, 0, 5, 20, 0);
    add("x39", 39, 1, 0, 39, 20, 0);
    add("gap40", 40, 0, 15, 0, 0, 0);
    add("gap59", 59, 0, 15, 0, 0, 0);
    add("x80", 80, 1, 1, 20, 20, 0);
    add("x620", 620, 1, 10, 20, 20, 0);
    add("x639", 639, 1, 10, 39, 20, 0);
    add("x659", 659, 0, 15, 0, 0, 0);
    add("x660", 660, 0, 15, 0, 0, 0);
    add("x700", 700, 0, 15, 0, 0, 0);
    addb("border60", 60, BEXP);
    addb("border99", 99, BEXP);
    addb("border600", 600, BEXP);
    addb("border61", 61, 0);
    line(120, 0, 719);
    drive(1'b0, 1'b0, 0, 0);
    cur_pin = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    cur_name = "idle";

    add("y99", 20, 0, 15, 0, 0, 0);
    line(99, 0, 719);
    add("y140", 20, 0, 15, 0, 0, 0);
    line(140, 0, 719);
    add("y100", 10, 1, 0, 10, 0, 0);
    line(100, 0, 100);
    add("y139", 70, 1, 1, 10, 39, 0);
    line(139, 0, 100);

    // Skipped x=79.
    line(120, 0, 78);
    add("skip_sync", 80, 0, 15, 0, 0, 1);
    add("skip_once", 81, 0, 15, 0, 0, 0);
    add("skip_rest", 125, 0, 15, 0, 0, 0);
    line(120, 80, 200);
    add("relock", 80, 1, 1, 20, 20, 0);
    line(120, 0, 100);

    // pix_valid gap.
    line(120, 0, 30);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 500, 500);
      cur_pin = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
      cur_name = "gap_idle";
    end
    add("gap_resume", 31, 1, 0, 31, 20, 0);
    line(120, 31, 60);

    // Reset mid-line.
    line(120, 0, 199);
    drive(1'b1, 1'b1, 200, 120);
    cur_pin = '{0, 2, 0, 0, 15, 0, 0, 0, 0};
    cur_name = "reset_mid";
    add("after_reset", 201, 0, 15, 0, 0, 0);
    line(120, 201, 210);
    add("relock_reset", 80, 1, 1, 20, 20, 0);
    line(120, 0, 100);

    // Random scans with idle cycles, skips, unlocked starts and occasional resets.
    for (int l = 0; l < 24; l++) begin
      r = int'($urandom_range(0, 7));
      y = (r == 7) ? int'($urandom_range(0, 1023)) : ys[r];
      xend = int'($urandom_range(600, 1023));
      x = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 50)) : 0;
      while (x <= xend) begin
        r = int'($urandom_range(0, 999));
        if (r < 3) begin
          drive(1'b1, 1'($urandom_range(0, 1)), x, y);
          x++;
        end else if (r < 120) begin
          drive(1'b0, 1'b0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        end else if (r < 125) begin
          x = x + int'($urandom_range(1, 3));
        end else begin
          drive(1'b0, 1'b1, x, y);
          x++;
        end
      end
    end
    drive(1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, 0);
    done = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_x     = '0;
    pix_y     = '0;
    cur_pin   = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    cur_name  = "";
    fork
      stimulus();
      compare_loop();
    join
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
